// File: rtl/ipcore_ingress_fifo.sv
// Ingress FIFO ahead of ipcore: valid/ready in and out, first-word fall-through.
// Define IPCORE_INGRESS_CNT_EN to add the xfer_cnt push counter and drop_attempt sticky flag.
module ipcore_ingress_fifo #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
`ifdef IPCORE_INGRESS_CNT_EN
  output logic                     empty,
  output logic [31:0]              xfer_cnt,
  output logic                     drop_attempt
`else
  output logic                     empty
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push, pop;

  // Handshake readiness comes only from stored level, so a full FIFO
  // refuses a word even when ipcore pops in the same cycle.
  assign s_ready     = (level_q != LVL_W'(DEPTH));
  assign m_valid     = (level_q != '0);
  assign m_data      = mem_q[rd_ptr_q];
  assign level       = level_q;
  assign empty       = (level_q == '0);
  assign almost_full = (level_q >= LVL_W'(AFULL_THRESH));

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; level gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef IPCORE_INGRESS_CNT_EN
  logic [31:0] xfer_cnt_q, xfer_cnt_d;
  logic        drop_attempt_q, drop_attempt_d;

  always_comb begin
    xfer_cnt_d     = push ? xfer_cnt_q + 32'd1 : xfer_cnt_q;
    drop_attempt_d = drop_attempt_q | (s_valid & ~s_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q     <= '0;
      drop_attempt_q <= 1'b0;
    end else begin
      xfer_cnt_q     <= xfer_cnt_d;
      drop_attempt_q <= drop_attempt_d;
    end
  end

  assign xfer_cnt     = xfer_cnt_q;
  assign drop_attempt = drop_attempt_q;
`endif

endmodule

// File: tb/tb_ipcore_ingress_fifo.sv
// Bench for ipcore_ingress_fifo: fill/drain vector table plus queue-model checks.
module tb_ipcore_ingress_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid, s_ready, m_valid, m_ready;
  logic [DATA_W-1:0] s_data, m_data;
  logic [3:0]        level;
  logic              almost_full, empty;
`ifdef IPCORE_INGRESS_CNT_EN
  logic [31:0]       xfer_cnt;
  logic              drop_attempt;
  int unsigned       mdl_cnt;
  bit                mdl_drop;
`endif

  ipcore_ingress_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level), .almost_full(almost_full),
`ifdef IPCORE_INGRESS_CNT_EN
    .empty(empty), .xfer_cnt(xfer_cnt), .drop_attempt(drop_attempt)
`else
    .empty(empty)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q[$];

  typedef struct {
    bit          sv;
    logic [31:0] sd;
    bit          mr;
    int          exp_level;
    bit          exp_s_ready;
    bit          exp_m_valid;
    bit          exp_afull;
    logic [31:0] exp_mdata;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock with the queue model: outputs checked before the edge, model advanced after.
  task automatic mcycle(input bit sv, input logic [31:0] sd, input bit mr);
    bit do_push, do_pop;
    int sz;
    s_valid = sv; s_data = sd; m_ready = mr; rst = 1'b0;
    sz = q.size();
    check("level", 32'(level), 32'(sz));
    check("s_ready", 32'(s_ready), 32'(sz != DEPTH));
    check("m_valid", 32'(m_valid), 32'(sz != 0));
    check("empty", 32'(empty), 32'(sz == 0));
    check("almost_full", 32'(almost_full), 32'(sz >= AFULL));
    if (sz > 0) check("m_data", m_data, q[0]);
    do_push = sv && (sz < DEPTH);
    do_pop  = mr && (sz > 0);
    @(posedge clk); #1;
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(sd);
`ifdef IPCORE_INGRESS_CNT_EN
    if (do_push) mdl_cnt++;
    if (sv && sz == DEPTH) mdl_drop = 1'b1;
`endif
  endtask

  task automatic do_reset(input bit sv, input bit mr);
    rst = 1'b1; s_valid = sv; m_ready = mr; s_data = 32'hDEAD_0000;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
`ifdef IPCORE_INGRESS_CNT_EN
    mdl_cnt = 0; mdl_drop = 1'b0;
`endif
  endtask

  initial begin
    int pushed;
    int budget;
    vec_t v;

    // Fill with 0x01..0x08 plus a rejected 0x09, then drain everything.
    for (int i = 0; i < 9; i++) begin
      v.sv = 1'b1; v.sd = 32'(i + 1); v.mr = 1'b0;
      v.exp_level   = (i + 1 > DEPTH) ? DEPTH : i + 1;
      v.exp_s_ready = (v.exp_level != DEPTH);
      v.exp_m_valid = 1'b1;
      v.exp_afull   = (v.exp_level >= AFULL);
      v.exp_mdata   = 32'h1;
      tbl.push_back(v);
    end
    for (int j = 0; j < 8; j++) begin
      v.sv = 1'b0; v.sd = 32'h0; v.mr = 1'b1;
      v.exp_level   = 7 - j;
      v.exp_s_ready = 1'b1;
      v.exp_m_valid = (v.exp_level != 0);
      v.exp_afull   = (v.exp_level >= AFULL);
      v.exp_mdata   = 32'(j + 2);
      tbl.push_back(v);
    end

    s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
`ifdef IPCORE_INGRESS_CNT_EN
    mdl_cnt = 0; mdl_drop = 1'b0;
`endif

    // Reset held two cycles with s_valid high.
    rst = 1'b1; s_valid = 1'b1; s_data = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_afull", 32'(almost_full), 32'd0);
    rst = 1'b0; s_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_m_valid", 32'(m_valid), 32'd0);
    check("post_rst_level", 32'(level), 32'd0);

    // Table-driven fill and drain.
    foreach (tbl[k]) begin
      s_valid = tbl[k].sv; s_data = tbl[k].sd; m_ready = tbl[k].mr;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_level", k), 32'(level), 32'(tbl[k].exp_level));
      check($sformatf("tbl%0d_s_ready", k), 32'(s_ready), 32'(tbl[k].exp_s_ready));
      check($sformatf("tbl%0d_m_valid", k), 32'(m_valid), 32'(tbl[k].exp_m_valid));
      check($sformatf("tbl%0d_afull", k), 32'(almost_full), 32'(tbl[k].exp_afull));
      if (tbl[k].exp_m_valid) check($sformatf("tbl%0d_m_data", k), m_data, tbl[k].exp_mdata);
    end
    s_valid = 1'b0; m_ready = 1'b0;
    check("drained_empty", 32'(empty), 32'd1);

    // Steady push+pop at level 3 for 20 cycles.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) mcycle(1'b1, 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 20; i++) mcycle(1'b1, 32'h200 + 32'(i), 1'b1);
    check("steady_level", 32'(level), 32'd3);
    while (q.size() > 0) mcycle(1'b0, 32'h0, 1'b1);

    // Random traffic: 1000 accepted words against the queue model.
    pushed = 0; budget = 0;
    while (pushed < 1000 && budget < 20000) begin
      bit sv;
      sv = ($urandom_range(0, 3) != 0);
      if (sv && q.size() < DEPTH) pushed++;
      mcycle(sv, $urandom, ($urandom_range(0, 2) != 0));
      budget++;
    end
    check("rand_pushed", 32'(pushed), 32'd1000);
    budget = 0;
    while (q.size() > 0 && budget < 100) begin
      mcycle(1'b0, 32'h0, 1'b1);
      budget++;
    end
    check("rand_drain_empty", 32'(empty), 32'd1);

    // Mid-operation reset after an overfill attempt.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) mcycle(1'b1, 32'h300 + 32'(i), 1'b0);
    mcycle(1'b1, 32'h3FF, 1'b0);
    for (int i = 0; i < 3; i++) mcycle(1'b0, 32'h0, 1'b1);
`ifdef IPCORE_INGRESS_CNT_EN
    check("cnt_before_rst", xfer_cnt, 32'(mdl_cnt));
    check("drop_before_rst", 32'(drop_attempt), 32'(mdl_drop));
`endif
    check("mid_level_before_rst", 32'(level), 32'd5);
    do_reset(1'b1, 1'b1);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
`ifdef IPCORE_INGRESS_CNT_EN
    check("mid_rst_cnt", xfer_cnt, 32'd0);
    check("mid_rst_drop", 32'(drop_attempt), 32'd0);
`endif
    mcycle(1'b1, 32'hAA, 1'b0);
    check("first_after_rst", m_data, 32'hAA);
    mcycle(1'b0, 32'h0, 1'b1);
    check("final_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ipcore_ingress_fifo.md
Name: ipcore_ingress_fifo

Overview:
- Ingress buffering stage directly upstream of ipcore.
- Accepts words from the test environment or upstream logic on a valid/ready interface, stores them in a small synchronous FIFO, and presents them to ipcore on a second valid/ready interface.
- Decouples upstream stalls from ipcore and reports occupancy and almost-full status for flow control and coverage.

Parameters:
DATA_W, 32, width of each data word.
DEPTH, 8, number of FIFO entries; must be a power of 2 and at least 2.
AFULL_THRESH, 6, almost_full asserts when level >= AFULL_THRESH; legal range 1..DEPTH.

Ports:
clk  input  1  single clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
s_valid  input  1  upstream word valid.
s_ready  output  1  FIFO can accept a word.
s_data  input  DATA_W  upstream word.
m_valid  output  1  word available to ipcore.
m_ready  input  1  ipcore accepts the word.
m_data  output  DATA_W  word presented to ipcore.
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
almost_full  output  1  level >= AFULL_THRESH.
empty  output  1  level == 0.

Behaviour:
- Reset is synchronous and active-high: rst sampled high at a clk edge clears all state.
- Reset values: level=0, empty=1, almost_full=0, m_valid=0, s_ready=1 after that edge. m_data is don't-care while m_valid=0.
- Push: s_valid && s_ready at an edge writes s_data at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: m_valid && m_ready at an edge advances rd_ptr modulo DEPTH.
- s_ready = (level != DEPTH). It is registered-state only, with no combinational path from m_ready. A full FIFO does not accept a word in the same cycle as a pop.
- m_valid = (level != 0). m_data = mem[rd_ptr], read combinationally from storage (first-word fall-through).
- Latency: a word pushed at edge N is visible on m_valid/m_data after edge N; it can be popped at edge N+1 at the earliest. There is no bypass path.
- Level update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged; both pointers advance.
  - neither: unchanged.
- empty and almost_full are decoded from level, so they are registered-state and glitch-free.
- Ordering is strict FIFO; no word is lost or duplicated.
- Full: s_ready=0. s_valid is ignored and s_data is not written.
- Empty: m_valid=0. m_ready is ignored.
- Pointer wrap: wr_ptr and rd_ptr wrap from DEPTH-1 to 0 with no bubble.
- Handshake stability: once m_valid=1, m_valid and m_data hold until popped or reset. Upstream is expected to hold s_data while s_valid=1 && s_ready=0, but the FIFO does not depend on this.
- Reset mid-operation: contents are discarded and pointers return to 0. Handshakes presented in the reset cycle have no effect.
- Pointer width is $clog2(DEPTH). level is one bit wider so that the value DEPTH is representable.

Optional Feature:
Macro: IPCORE_INGRESS_CNT_EN
- Defined:
  - Adds output xfer_cnt, 32 bits: count of accepted pushes.
  - Resets to 0 and increments by 1 on each push.
  - Wraps from 0xFFFFFFFF to 0.
  - Also adds output drop_attempt, 1 bit: sticky, set when s_valid=1 while s_ready=0; cleared only by rst.
- Undefined: neither port exists and no counter logic is synthesised. All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with s_valid=1 -> level=0, empty=1, m_valid=0, s_ready=1, and no word appears after rst deasserts.
- Fill (DEPTH=8, AFULL_THRESH=6): push 0x01..0x08 with m_ready=0 -> almost_full rises after the 6th push, s_ready=0 and level=8 after the 8th; a 9th word 0x09 held on s_valid is not accepted.
- Drain and order: from full, set m_ready=1 -> m_data sequence 0x01..0x08 on consecutive cycles, then empty=1 and m_valid=0.
- Simultaneous push/pop: with level=3, push and pop every cycle for 20 cycles -> level stays 3, output order matches input order, and pointers wrap at least twice.
- Random backpressure: 1000 words with random s_valid/m_ready -> scoreboard shows identical in-order stream, level always in 0..8, and no push while full.
- Mid-operation reset (IPCORE_INGRESS_CNT_EN defined): push 5 words with a push attempted while full earlier, then assert rst -> level=0, xfer_cnt=0, drop_attempt=0, and the next pushed word 0xAA is the first word seen on m_data.
